pc_fetch: RTL and testbench

Fetch stage feeding the instruction ROM (5-bit word address, 32-bit instruction out, combinational read). Holds the program counter and drives the ROM word address. Registers the returned instruction with its PC into a fetch register, presented to decode through a valid/ready handshake. Handles branch/jump redirect, stall, halt and an optional misaligned-target trap.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/pc_fetch_if.sv | 29 ++
 rtl/pc_fetch_pc_next.sv | 34 +++
 rtl/pc_fetch.sv | 105 ++++++++++
 tb/tb_pc_fetch.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and defaults: FSM state enum, reset PC, ROM address width, PC step.
package riscv_pkg;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2,
    StFault  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned IM_AW_DEFAULT    = 5;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: ROM port, redirect/control inputs and the decode-facing fetch register.
interface pc_fetch_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned IM_AW = 5
);
  logic [IM_AW-1:0] addressIM;
  logic [N-1:0]     inst;
  logic             branch_taken;
  logic [N-1:0]     branch_target;
  logic             stall;
  logic             halt_req;
  logic             fetch_ready;
  logic             fetch_valid;
  logic [N-1:0]     fetch_inst;
  logic [N-1:0]     fetch_pc;
  logic [N-1:0]     pc;
  logic             misalign_fault;
  logic             halted;

  modport master (
    output addressIM, fetch_valid, fetch_inst, fetch_pc, pc, misalign_fault, halted,
    input  inst, branch_taken, branch_target, stall, halt_req, fetch_ready
  );

  modport slave (
    input  addressIM, fetch_valid, fetch_inst, fetch_pc, pc, misalign_fault, halted,
    output inst, branch_taken, branch_target, stall, halt_req, fetch_ready
  );
endinterface

// File: rtl/pc_fetch_pc_next.sv
// Next-PC selection: hold / pc+4 / redirect target, priority halt > branch > stall > advance.
// With FETCH_MISALIGN_TRAP_EN the raw target is loaded; otherwise the low two bits are cleared.
module pc_next import riscv_pkg::*; #(
  parameter int unsigned N = 32
) (
  input  logic         i_run,
  input  logic         i_halt,
  input  logic         i_branch,
  input  logic         i_advance,
  input  logic [N-1:0] i_pc,
  input  logic [N-1:0] i_target,
  output logic [N-1:0] o_pc_next
);

  logic [N-1:0] w_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_target = i_target;
`else
  assign w_target = i_target & {{(N-2){1'b1}}, 2'b00};
`endif

  always_comb begin
    o_pc_next = i_pc;
    if (i_run && !i_halt) begin
      if (i_branch) begin
        o_pc_next = w_target;
      end else if (i_advance) begin
        o_pc_next = i_pc + N'(PC_STEP);
      end
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: PC register, ROM addressing, fetch register with valid/ready to decode.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module pc_fetch import riscv_pkg::*; #(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT),
  parameter int unsigned  IM_AW    = IM_AW_DEFAULT
) (
  input logic        clk,
  input logic        rst_n,
  pc_fetch_if.master bus
);

  fetch_state_e r_state, w_state_d;
  logic [N-1:0] r_pc, w_pc_d;
  logic         r_valid, w_valid_d;
  logic [N-1:0] r_inst, w_inst_d;
  logic [N-1:0] r_fpc, w_fpc_d;
  logic         w_run;
  logic         w_advance;

  assign w_run     = (r_state == StRun);
  // Stall dominates consume: a stalled, accepted entry stays valid.
  assign w_advance = !bus.stall && (!r_valid || bus.fetch_ready);

  pc_next #(.N(N)) u_pc_next (
    .i_run     (w_run),
    .i_halt    (bus.halt_req),
    .i_branch  (bus.branch_taken),
    .i_advance (w_advance),
    .i_pc      (r_pc),
    .i_target  (bus.branch_target),
    .o_pc_next (w_pc_d)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault, w_fault_d;
`endif

  always_comb begin
    w_state_d = r_state;
    w_valid_d = r_valid;
    w_inst_d  = r_inst;
    w_fpc_d   = r_fpc;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_fault_d = r_fault;
`endif
    unique case (r_state)
      StBoot: w_state_d = StRun;
      StRun: begin
        if (bus.halt_req) begin
          w_valid_d = 1'b0;
          w_state_d = StHalted;
        end else if (bus.branch_taken) begin
          w_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (bus.branch_target[1:0] != 2'b00) begin
            w_state_d = StFault;
            w_fault_d = 1'b1;
          end
`endif
        end else if (w_advance) begin
          w_inst_d  = bus.inst;
          w_fpc_d   = r_pc;
          w_valid_d = 1'b1;
        end
      end
      StHalted, StFault: w_valid_d = 1'b0;
      default: w_state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StBoot;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_fpc   <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_valid <= w_valid_d;
      r_inst  <= w_inst_d;
      r_fpc   <= w_fpc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fault <= 1'b0;
    else        r_fault <= w_fault_d;
  end
  assign bus.misalign_fault = r_fault;
`else
  assign bus.misalign_fault = 1'b0;
`endif

  assign bus.addressIM   = r_pc[IM_AW+1:2];
  assign bus.pc          = r_pc;
  assign bus.fetch_valid = r_valid;
  assign bus.fetch_inst  = r_inst;
  assign bus.fetch_pc    = r_fpc;
  assign bus.halted      = (r_state == StHalted);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, backpressure, redirect, alias, wrap, halt, reset.
module tb_pc_fetch;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [31:0] rom [32];

  pc_fetch_if #(.N(32), .IM_AW(5)) bus ();
  pc_fetch_if #(.N(32), .IM_AW(5)) bus_w ();

  pc_fetch #(.N(32), .RESET_PC(32'h0000_0000), .IM_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Second instance starting just below the 32-bit wrap point.
  pc_fetch #(.N(32), .RESET_PC(32'hFFFF_FFFC), .IM_AW(5)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  assign bus.inst             = rom[bus.addressIM];
  assign bus_w.inst           = rom[bus_w.addressIM];
  assign bus_w.branch_taken   = 1'b0;
  assign bus_w.branch_target  = 32'h0;
  assign bus_w.stall          = 1'b0;
  assign bus_w.halt_req       = 1'b0;
  assign bus_w.fetch_ready    = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] exp_inst,
                             input logic [31:0] exp_pc);
    check_val({tag, "_valid"}, 32'(bus.fetch_valid), 32'd1);
    check_val({tag, "_inst"}, bus.fetch_inst, exp_inst);
    check_val({tag, "_fpc"}, bus.fetch_pc, exp_pc);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0] = 32'h11;
    rom[1] = 32'h22;
    rom[2] = 32'h33;
    rom[3] = 32'h44;

    rst_n              = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.branch_target  = 32'h0;
    bus.stall          = 1'b0;
    bus.halt_req       = 1'b0;
    bus.fetch_ready    = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_pc", bus.pc, 32'h0);
    check_val("rst_valid", 32'(bus.fetch_valid), 32'd0);
    check_val("rst_inst", bus.fetch_inst, 32'h0);
    check_val("rst_fpc", bus.fetch_pc, 32'h0);
    check_val("rst_halted", 32'(bus.halted), 32'd0);
    check_val("rst_fault", 32'(bus.misalign_fault), 32'd0);
    check_val("rst_wrap_pc", bus_w.pc, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Edge 1: BOOT, nothing captured.
    step();
    check_val("boot_valid", 32'(bus.fetch_valid), 32'd0);
    check_val("boot_pc", bus.pc, 32'h0);
    // Edge 2: first capture.
    step();
    check_fetch("seq0", 32'h11, 32'h0);
    check_val("wrap_fpc", bus_w.fetch_pc, 32'hFFFF_FFFC);
    check_val("wrap_inst", bus_w.fetch_inst, 32'hA000_001F);
    check_val("wrap_pc", bus_w.pc, 32'h0);
    step();
    check_fetch("seq1", 32'h22, 32'h4);
    step();
    check_fetch("seq2", 32'h33, 32'h8);
    check_val("seq2_pc", bus.pc, 32'hC);

    // Redirect with simultaneous stall.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    bus.stall         = 1'b1;
    step();
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b0;
    check_val("br_bubble", 32'(bus.fetch_valid), 32'd0);
    check_val("br_pc", bus.pc, 32'h40);
    step();
    check_fetch("br_tgt", 32'hA000_0010, 32'h40);

    // Backpressure for three cycles.
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_fetch("bp_hold", 32'hA000_0010, 32'h40);
      check_val("bp_pc", bus.pc, 32'h44);
    end
    bus.fetch_ready = 1'b1;
    step();
    check_fetch("bp_res0", 32'hA000_0011, 32'h44);
    step();
    check_fetch("bp_res1", 32'hA000_0012, 32'h48);

    // Stall dominates consume.
    bus.stall = 1'b1;
    step();
    bus.stall = 1'b0;
    check_fetch("st_hold", 32'hA000_0012, 32'h48);
    check_val("st_pc", bus.pc, 32'h4C);

    // Alias past the top of the ROM.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h7C;
    step();
    bus.branch_taken = 1'b0;
    check_val("al_pc", bus.pc, 32'h7C);
    check_val("al_addr31", 32'(bus.addressIM), 32'd31);
    step();
    check_fetch("al_7c", 32'hA000_001F, 32'h7C);
    check_val("al_addr0", 32'(bus.addressIM), 32'd0);
    step();
    check_fetch("al_80", 32'h11, 32'h80);

    // Misaligned redirect.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h42;
    step();
    bus.branch_taken = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check_val("mis_fault", 32'(bus.misalign_fault), 32'd1);
    check_val("mis_valid", 32'(bus.fetch_valid), 32'd0);
    check_val("mis_pc", bus.pc, 32'h42);
    step();
    check_val("mis_sticky", 32'(bus.misalign_fault), 32'd1);
    check_val("mis_valid2", 32'(bus.fetch_valid), 32'd0);
    check_val("mis_pc2", bus.pc, 32'h42);
`else
    check_val("mis_fault", 32'(bus.misalign_fault), 32'd0);
    check_val("mis_valid", 32'(bus.fetch_valid), 32'd0);
    check_val("mis_pc", bus.pc, 32'h40);
    step();
    check_fetch("mis_tgt", 32'hA000_0010, 32'h40);
    check_val("mis_fault2", 32'(bus.misalign_fault), 32'd0);
`endif

    // Asynchronous reset mid-run.
    rst_n = 1'b0;
    #1;
    check_val("ar_pc", bus.pc, 32'h0);
    check_val("ar_valid", 32'(bus.fetch_valid), 32'd0);
    check_val("ar_inst", bus.fetch_inst, 32'h0);
    check_val("ar_fpc", bus.fetch_pc, 32'h0);
    check_val("ar_fault", 32'(bus.misalign_fault), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check_fetch("ar_seq0", 32'h11, 32'h0);

    // Halt wins over a same-cycle branch.
    bus.halt_req      = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    step();
    bus.halt_req     = 1'b0;
    bus.branch_taken = 1'b0;
    check_val("h_halted", 32'(bus.halted), 32'd1);
    check_val("h_pc", bus.pc, 32'h4);
    check_val("h_valid", 32'(bus.fetch_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("h_stay", 32'(bus.halted), 32'd1);
      check_val("h_pc_frz", bus.pc, 32'h4);
      check_val("h_valid0", 32'(bus.fetch_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
